// File: rtl/maxpool_backward_if.sv
// Control, operand and result bundle for the 2x2 max-pool backward stage.
// The master drives start and both operand tensors; the slave returns grad_in, busy and done.
interface maxpool_backward_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 28
);
    localparam int OUT_SIZE = IN_SIZE / 2;

    logic                         start;
    logic signed [DATA_WIDTH-1:0] fwd_feature [0:CHANNELS-1][0:IN_SIZE-1][0:IN_SIZE-1];
    logic signed [DATA_WIDTH-1:0] grad_out    [0:CHANNELS-1][0:OUT_SIZE-1][0:OUT_SIZE-1];
    logic signed [DATA_WIDTH-1:0] grad_in     [0:CHANNELS-1][0:IN_SIZE-1][0:IN_SIZE-1];
    logic                         busy;
    logic                         done;

    modport master (output start, fwd_feature, grad_out, input grad_in, busy, done);
    modport slave  (input start, fwd_feature, grad_out, output grad_in, busy, done);
endinterface

// File: rtl/maxpool_backward.sv
// 2x2 max-pool backward: routes each pooled gradient to the argmax of its forward window,
// one window per clock, zeroing the other three positions.
module maxpool_backward #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 28,
    parameter int POOL       = 2
) (
    input  logic              clk,
    input  logic              reset,
    maxpool_backward_if.slave bus
);
    localparam int OUT_SIZE = IN_SIZE / 2;
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int IW       = OW + 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
    localparam logic [OW-1:0] RC_LAST = OW'(OUT_SIZE - 1);

    if (POOL != 2) begin : g_bad_pool
        $error("maxpool_backward: only POOL=2 is supported");
    end
    if ((IN_SIZE % 2) != 0) begin : g_bad_size
        $error("maxpool_backward: IN_SIZE must be even");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;
    state_t state_reg, state_next;

    logic [CW-1:0] ch_reg;
    logic [OW-1:0] r_reg, q_reg;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          win_en, cnt_clear, last_win;
    logic [IW-1:0] row0, row1, col0, col1;
    logic signed [DATA_WIDTH-1:0] a, b, x, y, g, best;
    logic [1:0]    sel;
    logic signed [DATA_WIDTH-1:0] grad_reg [0:CHANNELS-1][0:IN_SIZE-1][0:IN_SIZE-1];

    assign row0 = {r_reg, 1'b0};
    assign row1 = {r_reg, 1'b1};
    assign col0 = {q_reg, 1'b0};
    assign col1 = {q_reg, 1'b1};
    assign a = bus.fwd_feature[ch_reg][row0][col0];
    assign b = bus.fwd_feature[ch_reg][row0][col1];
    assign x = bus.fwd_feature[ch_reg][row1][col0];
    assign y = bus.fwd_feature[ch_reg][row1][col1];
    assign g = bus.grad_out[ch_reg][r_reg][q_reg];
    assign last_win = (ch_reg == CH_LAST) && (r_reg == RC_LAST) && (q_reg == RC_LAST);

    // Strict greater-than chain: on ties the earliest of a,b,x,y keeps the gradient.
    always_comb begin
        best = a;
        sel  = 2'd0;
        if (b > best) begin best = b; sel = 2'd1; end
        if (x > best) begin best = x; sel = 2'd2; end
        if (y > best) begin best = y; sel = 2'd3; end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_RUN;
            S_RUN:    if (last_win)  state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        win_en    = 1'b0;
        cnt_clear = 1'b0;
        busy_next = busy_reg;
        done_next = 1'b0;
        case (state_reg)
            S_IDLE:   if (bus.start) begin cnt_clear = 1'b1; busy_next = 1'b1; end
            S_RUN:    begin win_en = 1'b1; busy_next = 1'b1; end
            S_FINISH: begin done_next = 1'b1; busy_next = 1'b0; end
            default:  busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_reg   <= '0;
            r_reg    <= '0;
            q_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
            if (cnt_clear) begin
                ch_reg <= '0;
                r_reg  <= '0;
                q_reg  <= '0;
            end else if (win_en) begin
                if (q_reg == RC_LAST) begin
                    q_reg <= '0;
                    if (r_reg == RC_LAST) begin
                        r_reg  <= '0;
                        ch_reg <= (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
                    end else begin
                        r_reg <= r_reg + 1'b1;
                    end
                end else begin
                    q_reg <= q_reg + 1'b1;
                end
            end
        end
    end

    // Every window owns four distinct elements, so a run overwrites the whole map without a clear pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int i = 0; i < IN_SIZE; i++)
                    for (int j = 0; j < IN_SIZE; j++)
                        grad_reg[c][i][j] <= '0;
        end else if (win_en) begin
            grad_reg[ch_reg][row0][col0] <= (sel == 2'd0) ? g : '0;
            grad_reg[ch_reg][row0][col1] <= (sel == 2'd1) ? g : '0;
            grad_reg[ch_reg][row1][col0] <= (sel == 2'd2) ? g : '0;
            grad_reg[ch_reg][row1][col1] <= (sel == 2'd3) ? g : '0;
        end
    end

    assign bus.grad_in = grad_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
endmodule
